// File: rtl/ip_arp_table_if.sv
// Lookup request and result channel between the LPM stage, the ARP resolver
// and the packet-process block.
interface ip_arp_table_if #(
  parameter int NUM_QUEUES     = 8,
  parameter int LUT_DEPTH_BITS = 5
);
  // Lookup request from the LPM stage
  logic [31:0]               next_hop_ip;
  logic [NUM_QUEUES-1:0]     lpm_output_port;
  logic                      lpm_vld;
  logic                      lpm_hit;
  logic                      lpm_rdy;

  // Head of the result FIFO toward the packet-process block
  logic [47:0]               next_hop_mac;
  logic [NUM_QUEUES-1:0]     output_port;
  logic                      arp_lookup_hit;
  logic                      lpm_lookup_hit;
  logic [LUT_DEPTH_BITS-1:0] arp_hit_index;
  logic                      arp_mac_vld;
  logic                      rd_arp_result;

  modport master (
    output next_hop_ip, lpm_output_port, lpm_vld, lpm_hit, rd_arp_result,
    input  lpm_rdy, next_hop_mac, output_port, arp_lookup_hit,
           lpm_lookup_hit, arp_hit_index, arp_mac_vld
  );

  modport slave (
    input  next_hop_ip, lpm_output_port, lpm_vld, lpm_hit, rd_arp_result,
    output lpm_rdy, next_hop_mac, output_port, arp_lookup_hit,
           lpm_lookup_hit, arp_hit_index, arp_mac_vld
  );
endinterface

// File: rtl/ip_arp_table.sv
// Next-hop ARP resolver: parallel search of a register-file ARP table, in-order
// result FIFO with credit backpressure, register access and hit/miss statistics.
module ip_arp_table #(
  parameter int NUM_QUEUES      = 8,
  parameter int LUT_DEPTH       = 32,
  parameter int LUT_DEPTH_BITS  = $clog2(LUT_DEPTH),
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                      clk,
  input  logic                      reset,

  ip_arp_table_if.slave             lk,

  input  logic [LUT_DEPTH_BITS-1:0] arp_rd_addr,
  input  logic                      arp_rd_req,
  output logic [47:0]               arp_rd_mac,
  output logic [31:0]               arp_rd_ip,
  output logic                      arp_rd_valid,
  output logic                      arp_rd_ack,

  input  logic [LUT_DEPTH_BITS-1:0] arp_wr_addr,
  input  logic                      arp_wr_req,
  input  logic [47:0]               arp_wr_mac,
  input  logic [31:0]               arp_wr_ip,
  input  logic                      arp_wr_valid,
  output logic                      arp_wr_ack,

  input  logic                      arp_clear_req,
  output logic                      arp_clear_ack,

  input  logic                      counters_clear,
  output logic [CNT_WIDTH-1:0]      arp_hit_count,
  output logic [CNT_WIDTH-1:0]      arp_miss_count
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] CREDITS = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};

  typedef struct packed {
    logic [31:0]           ip;
    logic [NUM_QUEUES-1:0] port;
    logic                  lpm_hit;
  } lookup_t;

  typedef struct packed {
    logic [47:0]               mac;
    logic [NUM_QUEUES-1:0]     port;
    logic                      arp_hit;
    logic                      lpm_hit;
    logic [LUT_DEPTH_BITS-1:0] index;
  } result_t;

  // ---------------------------------------------------------------- table
  logic [31:0]          tbl_ip    [LUT_DEPTH];
  logic [47:0]          tbl_mac   [LUT_DEPTH];
  logic [LUT_DEPTH-1:0] tbl_valid;

  // NOTE: the table is a register file searched in parallel, so it must be
  // reset explicitly; the FIFO storage below is never read while empty and
  // is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        tbl_ip[i]  <= '0;
        tbl_mac[i] <= '0;
      end
      tbl_valid <= '0;
    end else begin
      // Clear first so a same-cycle write leaves its own valid bit behind.
      if (arp_clear_req) tbl_valid <= '0;
      if (arp_wr_req) begin
        tbl_ip[arp_wr_addr]    <= arp_wr_ip;
        tbl_mac[arp_wr_addr]   <= arp_wr_mac;
        tbl_valid[arp_wr_addr] <= arp_wr_valid;
      end
    end
  end

  // ------------------------------------------------------ register access
  logic [47:0] rd_mac_next;
  logic [31:0] rd_ip_next;
  logic        rd_valid_next;

  // Forward a same-edge write/clear so a read returns the updated entry.
  always_comb begin
    rd_mac_next   = tbl_mac[arp_rd_addr];
    rd_ip_next    = tbl_ip[arp_rd_addr];
    rd_valid_next = tbl_valid[arp_rd_addr] & ~arp_clear_req;
    if (arp_wr_req && (arp_wr_addr == arp_rd_addr)) begin
      rd_mac_next   = arp_wr_mac;
      rd_ip_next    = arp_wr_ip;
      rd_valid_next = arp_wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arp_rd_mac    <= '0;
      arp_rd_ip     <= '0;
      arp_rd_valid  <= 1'b0;
      arp_rd_ack    <= 1'b0;
      arp_wr_ack    <= 1'b0;
      arp_clear_ack <= 1'b0;
    end else begin
      arp_rd_ack    <= arp_rd_req;
      arp_wr_ack    <= arp_wr_req;
      arp_clear_ack <= arp_clear_req;
      if (arp_rd_req) begin
        arp_rd_mac   <= rd_mac_next;
        arp_rd_ip    <= rd_ip_next;
        arp_rd_valid <= rd_valid_next;
      end
    end
  end

  // ------------------------------------------------------- lookup pipeline
  logic    accept;
  logic    s1_vld, s2_vld;
  lookup_t s1_d, s2_d;

  assign accept = lk.lpm_vld & lk.lpm_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      s2_vld <= s1_vld;
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_d <= '{ip: lk.next_hop_ip, port: lk.lpm_output_port, lpm_hit: lk.lpm_hit};
    s2_d <= s1_d;
  end

  logic                      match_hit;
  logic [LUT_DEPTH_BITS-1:0] match_idx;
  result_t                   push_res;

  // NOTE: combinational blocks use blocking assignments with every output
  // defaulted first, so no latches are inferred. Scanning downward lets the
  // lowest matching index be the last one written.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
      if (tbl_valid[i] && (tbl_ip[i] == s2_d.ip)) begin
        match_hit = 1'b1;
        match_idx = LUT_DEPTH_BITS'(i);
      end
    end
  end

  always_comb begin
    push_res.mac     = match_hit ? tbl_mac[match_idx] : 48'h0;
    push_res.port    = s2_d.port;
    push_res.arp_hit = match_hit;
    push_res.lpm_hit = s2_d.lpm_hit;
    push_res.index   = match_idx;
  end

  // ----------------------------------------------------------- result FIFO
  result_t                  fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS:0] wr_ptr, rd_ptr;
  logic                     fifo_empty, push, pop;
  result_t                  head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign push       = s2_vld;
  assign pop        = lk.rd_arp_result & ~fifo_empty;
  assign head       = fifo_mem[rd_ptr[FIFO_DEPTH_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[FIFO_DEPTH_BITS-1:0]] <= push_res;
  end

  // NOTE: sequential state is updated with non-blocking assignments only so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign lk.arp_mac_vld    = ~fifo_empty;
  assign lk.next_hop_mac   = fifo_empty ? 48'h0 : head.mac;
  assign lk.output_port    = fifo_empty ? '0    : head.port;
  assign lk.arp_lookup_hit = ~fifo_empty & head.arp_hit;
  assign lk.lpm_lookup_hit = ~fifo_empty & head.lpm_hit;
  assign lk.arp_hit_index  = fifo_empty ? '0    : head.index;

  // --------------------------------------------------------------- credits
  // reserved covers both pipeline stages and the FIFO, so the FIFO cannot
  // overflow even with every stage occupied.
  logic [FIFO_DEPTH_BITS:0] reserved, reserved_next;
  logic                     rdy_q;

  always_comb begin
    reserved_next = reserved;
    if (accept && !pop)      reserved_next = reserved + 1'b1;
    else if (pop && !accept) reserved_next = reserved - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reserved <= '0;
      rdy_q    <= 1'b0;
    end else begin
      reserved <= reserved_next;
      rdy_q    <= (reserved_next < CREDITS);
    end
  end

  assign lk.lpm_rdy = rdy_q;

  // ------------------------------------------------------------ statistics
  logic inc_hit, inc_miss;

  assign inc_hit  = push & push_res.lpm_hit &  push_res.arp_hit;
  assign inc_miss = push & push_res.lpm_hit & ~push_res.arp_hit;

  always_ff @(posedge clk) begin
    if (reset || counters_clear) begin
      arp_hit_count  <= '0;
      arp_miss_count <= '0;
    end else begin
      if (inc_hit && (arp_hit_count != '1))   arp_hit_count  <= arp_hit_count + 1'b1;
      if (inc_miss && (arp_miss_count != '1)) arp_miss_count <= arp_miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ip_arp_table.sv
// Directed testbench for ip_arp_table: lookup latency, priority, invalidation,
// clear, credit backpressure, write/compare ordering, saturation and reset.
module tb_ip_arp_table;

  localparam int NQ  = 8;
  localparam int LDB = 5;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic reset;

  logic [LDB-1:0] arp_rd_addr, arp_wr_addr;
  logic           arp_rd_req, arp_wr_req, arp_wr_valid;
  logic [47:0]    arp_rd_mac, arp_wr_mac;
  logic [31:0]    arp_rd_ip, arp_wr_ip;
  logic           arp_rd_valid, arp_rd_ack, arp_wr_ack;
  logic           arp_clear_req, arp_clear_ack, counters_clear;
  logic [CW-1:0]  arp_hit_count, arp_miss_count;

  ip_arp_table_if #(.NUM_QUEUES(NQ), .LUT_DEPTH_BITS(LDB)) lk ();

  ip_arp_table #(
    .NUM_QUEUES(NQ), .LUT_DEPTH(32), .LUT_DEPTH_BITS(LDB),
    .FIFO_DEPTH_BITS(2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .lk(lk),
    .arp_rd_addr(arp_rd_addr), .arp_rd_req(arp_rd_req),
    .arp_rd_mac(arp_rd_mac), .arp_rd_ip(arp_rd_ip),
    .arp_rd_valid(arp_rd_valid), .arp_rd_ack(arp_rd_ack),
    .arp_wr_addr(arp_wr_addr), .arp_wr_req(arp_wr_req),
    .arp_wr_mac(arp_wr_mac), .arp_wr_ip(arp_wr_ip),
    .arp_wr_valid(arp_wr_valid), .arp_wr_ack(arp_wr_ack),
    .arp_clear_req(arp_clear_req), .arp_clear_ack(arp_clear_ack),
    .counters_clear(counters_clear),
    .arp_hit_count(arp_hit_count), .arp_miss_count(arp_miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input logic [LDB-1:0] a, input logic [31:0] ip,
                          input logic [47:0] mac, input logic v);
    arp_wr_addr = a; arp_wr_ip = ip; arp_wr_mac = mac; arp_wr_valid = v;
    arp_wr_req  = 1'b1;
    tick();
    arp_wr_req  = 1'b0;
    check("wr_ack", 64'(arp_wr_ack), 64'd1);
  endtask

  task automatic lookup(input logic [31:0] ip, input logic [NQ-1:0] port, input logic h);
    lk.next_hop_ip = ip; lk.lpm_output_port = port; lk.lpm_hit = h;
    lk.lpm_vld = 1'b1;
    tick();
    lk.lpm_vld = 1'b0;
  endtask

  task automatic pop();
    lk.rd_arp_result = 1'b1;
    tick();
    lk.rd_arp_result = 1'b0;
  endtask

  task automatic lookup_check(input string tag, input logic [31:0] ip, input logic [NQ-1:0] port,
                              input logic exp_hit, input logic [LDB-1:0] exp_idx,
                              input logic [47:0] exp_mac);
    lookup(ip, port, 1'b1);
    tick();
    check({tag, "_vld_n1"}, 64'(lk.arp_mac_vld), 64'd0);
    tick();
    check({tag, "_vld"},  64'(lk.arp_mac_vld),    64'd1);
    check({tag, "_hit"},  64'(lk.arp_lookup_hit), 64'(exp_hit));
    check({tag, "_idx"},  64'(lk.arp_hit_index),  64'(exp_idx));
    check({tag, "_mac"},  64'(lk.next_hop_mac),   64'(exp_mac));
    check({tag, "_port"}, 64'(lk.output_port),    64'(port));
    pop();
  endtask

  localparam logic [31:0] IP_A = 32'h0A00_0001;
  localparam logic [31:0] IP_X = 32'hC0A8_0101;
  localparam logic [31:0] IP_Y = 32'h0B0B_0B0B;
  localparam logic [47:0] MAC_A = 48'h0011_2233_4455;
  localparam logic [47:0] MAC_5 = 48'hAAAA_0000_0005;
  localparam logic [47:0] MAC_2 = 48'hBBBB_0000_0002;
  localparam logic [47:0] MAC_7 = 48'hCCCC_0000_0007;

  initial begin
    int accepted;
    logic [NQ-1:0] exp_port;

    reset = 1'b1;
    lk.next_hop_ip = '0; lk.lpm_output_port = '0; lk.lpm_vld = 1'b0;
    lk.lpm_hit = 1'b0; lk.rd_arp_result = 1'b0;
    arp_rd_addr = '0; arp_rd_req = 1'b0; arp_wr_addr = '0; arp_wr_req = 1'b0;
    arp_wr_mac = '0; arp_wr_ip = '0; arp_wr_valid = 1'b0;
    arp_clear_req = 1'b0; counters_clear = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_rdy",  64'(lk.lpm_rdy),     64'd0);
    check("rst_vld",  64'(lk.arp_mac_vld), 64'd0);
    check("rst_hits", 64'(arp_hit_count),  64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_rdy", 64'(lk.lpm_rdy),     64'd1);
    check("post_rst_vld", 64'(lk.arp_mac_vld), 64'd0);
    check("post_rst_mac", 64'(lk.next_hop_mac), 64'd0);

    // Basic hit on entry 3
    wr_entry(5'd3, IP_A, MAC_A, 1'b1);
    lookup_check("t1", IP_A, 8'h04, 1'b1, 5'd3, MAC_A);
    check("t1_hitcnt", 64'(arp_hit_count), 64'd1);
    check("t1_empty",  64'(lk.arp_mac_vld), 64'd0);

    // Register read, then read racing a write to the same entry
    arp_rd_addr = 5'd3; arp_rd_req = 1'b1;
    tick();
    arp_rd_req = 1'b0;
    check("rd_ack", 64'(arp_rd_ack),   64'd1);
    check("rd_ip",  64'(arp_rd_ip),    64'(IP_A));
    check("rd_mac", 64'(arp_rd_mac),   64'(MAC_A));
    check("rd_v",   64'(arp_rd_valid), 64'd1);
    arp_rd_addr = 5'd9; arp_rd_req = 1'b1;
    wr_entry(5'd9, 32'h1234_5678, 48'h9999_8888_7777, 1'b1);
    arp_rd_req = 1'b0;
    check("rdfw_ip", 64'(arp_rd_ip),    64'h1234_5678);
    check("rdfw_v",  64'(arp_rd_valid), 64'd1);
    tick();
    check("rd_ack_pulse", 64'(arp_rd_ack), 64'd0);

    // Duplicate ip: lowest index wins, invalidation, bulk clear
    wr_entry(5'd5, IP_X, MAC_5, 1'b1);
    wr_entry(5'd2, IP_X, MAC_2, 1'b1);
    lookup_check("dup", IP_X, 8'h10, 1'b1, 5'd2, MAC_2);
    wr_entry(5'd2, IP_X, MAC_2, 1'b0);
    lookup_check("inval", IP_X, 8'h20, 1'b1, 5'd5, MAC_5);
    arp_clear_req = 1'b1;
    tick();
    arp_clear_req = 1'b0;
    check("clr_ack", 64'(arp_clear_ack), 64'd1);
    lookup_check("clr", IP_X, 8'h40, 1'b0, 5'd0, 48'h0);
    check("clr_miss", 64'(arp_miss_count), 64'd1);
    check("clr_hits", 64'(arp_hit_count),  64'd3);

    // Credit backpressure: six requests, only four fit
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      lk.next_hop_ip = 32'h0100_0000 + 32'(k);
      lk.lpm_output_port = 8'(1 << k);
      lk.lpm_hit = 1'b0;
      lk.lpm_vld = 1'b1;
      if (lk.lpm_rdy) accepted++;
      tick();
    end
    lk.lpm_vld = 1'b0;
    check("bp_accepted", 64'(accepted), 64'd4);
    check("bp_rdy_low",  64'(lk.lpm_rdy), 64'd0);
    tick();
    check("bp_head0", 64'(lk.output_port), 64'h01);
    pop();
    check("bp_rdy_back", 64'(lk.lpm_rdy), 64'd1);
    for (int k = 1; k < 4; k++) begin
      exp_port = 8'(1 << k);
      check("bp_order", 64'(lk.output_port), 64'(exp_port));
      pop();
    end
    check("bp_drained", 64'(lk.arp_mac_vld), 64'd0);
    check("bp_nocount", 64'(arp_miss_count), 64'd1);

    // Write landing in the stage-2 compare cycle is not seen by that lookup
    lookup(IP_Y, 8'h02, 1'b1);
    tick();
    arp_wr_addr = 5'd7; arp_wr_ip = IP_Y; arp_wr_mac = MAC_7; arp_wr_valid = 1'b1;
    arp_wr_req = 1'b1;
    tick();
    arp_wr_req = 1'b0;
    check("race_vld",  64'(lk.arp_mac_vld),    64'd1);
    check("race_miss", 64'(lk.arp_lookup_hit), 64'd0);
    check("race_mac",  64'(lk.next_hop_mac),   64'd0);
    pop();
    lookup_check("race_next", IP_Y, 8'h02, 1'b1, 5'd7, MAC_7);
    check("race_cnt_h", 64'(arp_hit_count),  64'd4);
    check("race_cnt_m", 64'(arp_miss_count), 64'd2);

    // Saturation at CNT_WIDTH=4, then clear racing an increment
    counters_clear = 1'b1;
    tick();
    counters_clear = 1'b0;
    check("cc_hits", 64'(arp_hit_count),  64'd0);
    check("cc_miss", 64'(arp_miss_count), 64'd0);
    for (int k = 0; k < 20; k++) begin
      lookup(IP_Y, 8'h01, 1'b1);
      tick();
      tick();
      pop();
    end
    check("sat_hits", 64'(arp_hit_count),  64'd15);
    check("sat_miss", 64'(arp_miss_count), 64'd0);
    lookup(IP_Y, 8'h01, 1'b1);
    tick();
    counters_clear = 1'b1;
    tick();
    counters_clear = 1'b0;
    check("cc_race_vld",  64'(lk.arp_mac_vld), 64'd1);
    check("cc_race_hits", 64'(arp_hit_count),  64'd0);
    pop();

    // Reset with three results queued and one in flight
    lk.next_hop_ip = IP_Y; lk.lpm_output_port = 8'h08; lk.lpm_hit = 1'b1;
    lk.lpm_vld = 1'b1;
    repeat (4) tick();
    lk.lpm_vld = 1'b0;
    tick();
    check("pre_rst_hits", 64'(arp_hit_count), 64'd3);
    check("pre_rst_vld",  64'(lk.arp_mac_vld), 64'd1);
    reset = 1'b1;
    tick();
    check("in_rst_vld",  64'(lk.arp_mac_vld), 64'd0);
    check("in_rst_hits", 64'(arp_hit_count),  64'd0);
    check("in_rst_rdy",  64'(lk.lpm_rdy),     64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("after_rst_rdy", 64'(lk.lpm_rdy),     64'd1);
    check("after_rst_vld", 64'(lk.arp_mac_vld), 64'd0);
    repeat (4) tick();
    check("no_stale_vld",  64'(lk.arp_mac_vld), 64'd0);
    check("no_stale_hits", 64'(arp_hit_count),  64'd0);
    lookup_check("rst_tbl", IP_Y, 8'h08, 1'b0, 5'd0, 48'h0);
    check("rst_tbl_miss", 64'(arp_miss_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
